// File: rtl/multdiv_pkg.sv
// Shared decode constants, exception codes and state encoding for the mul/div sequencer.
package multdiv_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam logic [3:0] RSTATUS_MUL = 4'd4;
  localparam logic [3:0] RSTATUS_DIV = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_timeout_counter.sv
// Counts WAIT cycles and flags the cycle in which the TIMEOUT-th WAIT cycle is reached.
// Only instantiated when MULTDIV_TIMEOUT_EN is defined.
module md_timeout_counter #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of WAIT cycles already completed; saturates at TIMEOUT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one R-type mul/div through the multi-cycle unit: latch, start pulse, stall, write-back.
// Optional WAIT timeout abort is built when MULTDIV_TIMEOUT_EN is defined.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 40,
  parameter int RSTATUS_REG = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              insn_valid,
  input  logic [4:0]        opcode,
  input  logic [4:0]        ALUop,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] operandA,
  input  logic [DATA_W-1:0] operandB,
  input  logic [DATA_W-1:0] data_result,
  input  logic              data_exception,
  input  logic              data_resultRDY,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic [DATA_W-1:0] md_opA,
  output logic [DATA_W-1:0] md_opB,
  output logic              stall,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output md_state_e         state_dbg
);

  // Handshake: insn_valid qualifies opcode/ALUop/rd/operands for a single-cycle decode in IDLE;
  // data_resultRDY is a one-cycle pulse with no backpressure, accepted only in WAIT.

  md_state_e         state, next_state;
  logic              is_md;
  logic              timeout_hit;
  logic [DATA_W-1:0] opa_q, opb_q, res_q;
  logic [4:0]        rd_q;
  logic              div_q, exc_q;

  assign is_md = insn_valid && (opcode == OPC_RTYPE) &&
                 ((ALUop == ALUOP_MUL) || (ALUop == ALUOP_DIV));

`ifdef MULTDIV_TIMEOUT_EN
  md_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state == IDLE) && is_md),
    .enable (state == WAIT),
    .expired(timeout_hit)
  );
`else
  // no counter in this build: the wait never expires
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      opa_q <= '0;
      opb_q <= '0;
      rd_q  <= '0;
      div_q <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && is_md) begin
        opa_q <= operandA;
        opb_q <= operandB;
        rd_q  <= rd;
        div_q <= (ALUop == ALUOP_DIV);
      end
      // a real ready pulse wins over a simultaneous timeout
      if ((state == WAIT) && (data_resultRDY || timeout_hit)) begin
        res_q <= data_result;
        exc_q <= data_resultRDY ? data_exception : 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    stall      = 1'b0;
    wb_en      = 1'b0;
    wb_reg     = '0;
    wb_data    = '0;
    case (state)
      IDLE: begin
        stall = is_md;
        if (is_md) next_state = START;
      end
      START: begin
        ctrl_MULT  = !div_q;
        ctrl_DIV   = div_q;
        stall      = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (data_resultRDY || timeout_hit) next_state = WB;
      end
      WB: begin
        wb_en = exc_q || (rd_q != 5'd0);
        if (exc_q) begin
          wb_reg  = 5'(RSTATUS_REG);
          wb_data = {{(DATA_W-4){1'b0}}, (div_q ? RSTATUS_DIV : RSTATUS_MUL)};
        end else begin
          wb_reg  = rd_q;
          wb_data = res_q;
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign md_opA    = opa_q;
  assign md_opB    = opb_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed and randomized bench for multdiv_sequencer; the bench plays the multdiv unit and
// predicts write-backs from operand arithmetic.
module tb_multdiv_sequencer;
  import multdiv_pkg::*;

  localparam int W = 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         insn_valid = 1'b0;
  logic [4:0]   opcode = '0, ALUop = '0, rd = '0;
  logic [W-1:0] operandA = '0, operandB = '0, data_result = '0;
  logic         data_exception = 1'b0, data_resultRDY = 1'b0;
  logic         ctrl_MULT, ctrl_DIV, stall, wb_en, busy;
  logic [W-1:0] md_opA, md_opB, wb_data;
  logic [4:0]   wb_reg;
  md_state_e    state_dbg;

  multdiv_sequencer #(.DATA_W(W), .TIMEOUT(40), .RSTATUS_REG(30)) dut (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .opcode(opcode), .ALUop(ALUop),
    .rd(rd), .operandA(operandA), .operandB(operandB), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_opA(md_opA), .md_opB(md_opB),
    .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy),
    .state_dbg(state_dbg)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: issues one mul/div (call just after a posedge), plays the unit, checks the outcome.
  // n_wait = WAIT cycle (1-based) carrying the ready pulse; rdy_en=0 means the unit never answers.
  task automatic run_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] r, input int n_wait, input bit rdy_en,
                        input bit start_rdy);
    logic [63:0]  prod;
    logic         exc_m;
    logic [W-1:0] res_m;
    int n_mul = 0, n_div = 0, n_stall = 0, pulse_c = -1, wb_c = -1;
    bit op_bad = 0, busy_wb = 0, busy_dec = 1;

    prod  = {32'b0, a} * {32'b0, b};
    exc_m = is_div ? (b == '0) : (prod[63:32] != 32'b0);
    res_m = is_div ? ((b == '0) ? '1 : a / b) : prod[31:0];
    if (!rdy_en) exc_m = 1'b1;
    exp_q.delete();
    obs_q.delete();
    if (exc_m) exp_q.push_back({5'd30, (is_div ? 32'd5 : 32'd4)});
    else if (r != 5'd0) exp_q.push_back({r, res_m});

    insn_valid = 1'b1; opcode = 5'b00000; ALUop = is_div ? 5'b00111 : 5'b00110;
    rd = r; operandA = a; operandB = b;
    for (int c = 0; c <= n_wait + 2; c++) begin
      if (c >= 1) begin
        operandA = $urandom;
        operandB = $urandom;
      end
      if (rdy_en && c == n_wait + 1) begin
        data_resultRDY = 1'b1; data_result = exc_m ? $urandom : res_m; data_exception = exc_m;
      end else if (start_rdy && c == 1) begin
        data_resultRDY = 1'b1; data_result = $urandom; data_exception = 1'b1;
      end else begin
        data_resultRDY = 1'b0; data_result = $urandom; data_exception = 1'b0;
      end
      @(negedge clock);
      if (ctrl_MULT) begin n_mul++; pulse_c = c; end
      if (ctrl_DIV) begin n_div++; pulse_c = c; end
      if (stall) n_stall++;
      if (c >= 1 && (md_opA !== a || md_opB !== b)) op_bad = 1;
      if (wb_en) begin
        obs_q.push_back({wb_reg, wb_data});
        if (wb_c < 0) wb_c = c;
      end
      if (c == 0) busy_dec = busy;
      if (c == n_wait + 2) busy_wb = busy;
      @(posedge clock);
      #1;
    end
    insn_valid = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;

    check("mul_pulses", n_mul, is_div ? 0 : 1);
    check("div_pulses", n_div, is_div ? 1 : 0);
    check("pulse_cycle", pulse_c, 1);
    check("stall_cycles", n_stall, n_wait + 2);
    check("opnd_hold", op_bad, 0);
    check("busy_decode", busy_dec, 0);
    check("busy_wb", busy_wb, 1);
    check("idle_after", busy, 0);
    check("wb_count", obs_q.size(), exp_q.size());
    if (exp_q.size() > 0) check("wb_cycle", wb_c, n_wait + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check("wb_entry", obs_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    bit bad;
    logic [W-1:0] ra, rb;

    // reset state
    #12;
    check("rst_outs", {ctrl_MULT, ctrl_DIV, stall, wb_en, busy}, 5'b0);
    check("rst_ops", {md_opA, md_opB, wb_data, wb_reg}, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("post_rst_state", state_dbg, IDLE);

    // non-mul/div instructions must not trigger
    bad = 0;
    insn_valid = 1'b1; opcode = 5'b00000; ALUop = 5'b00000; #1; if (stall) bad = 1;
    opcode = 5'b00001; ALUop = 5'b00110; #1; if (stall) bad = 1;
    insn_valid = 1'b0; opcode = 5'b00000; ALUop = 5'b00111; #1; if (stall) bad = 1;
    @(posedge clock); #1; if (busy) bad = 1;
    check("no_trigger", bad, 0);

    // directed: mul 7*6 -> r3, 34 stall cycles
    run_op(1'b0, 32'd7, 32'd6, 5'd3, 32, 1'b1, 1'b0);
    // div by zero -> r30 = 5
    run_op(1'b1, 32'd100, 32'd0, 5'd9, 12, 1'b1, 1'b0);
    // mul to r0 -> no write-back
    run_op(1'b0, 32'd11, 32'd3, 5'd0, 5, 1'b1, 1'b0);
    // ready during START is ignored
    run_op(1'b0, 32'd25, 32'd4, 5'd12, 3, 1'b1, 1'b1);
    // mul overflow -> r30 = 4
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd14, 7, 1'b1, 1'b0);
    // back-to-back mul then div
    run_op(1'b0, 32'd12, 32'd13, 5'd7, 4, 1'b1, 1'b0);
    run_op(1'b1, 32'd1000, 32'd7, 5'd8, 1, 1'b1, 1'b0);
    // ready exactly in WAIT cycle 40 (with the timeout build, ready wins)
    run_op(1'b1, 32'd99, 32'd9, 5'd21, 40, 1'b1, 1'b0);

    // reset in WAIT cycle 10 abandons the operation
    insn_valid = 1'b1; opcode = 5'b00000; ALUop = 5'b00110; rd = 5'd5;
    operandA = 32'd9; operandB = 32'd9;
    repeat (11) @(posedge clock);
    #1;
    insn_valid = 1'b0;
    check("busy_before_rst", busy, 1);
    reset = 1'b0;
    #1;
    check("rst_wait_outs", {ctrl_MULT, ctrl_DIV, stall, wb_en, busy}, 5'b0);
    check("rst_wait_ops", {md_opA, md_opB, wb_data, wb_reg}, '0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    data_resultRDY = 1'b1; data_result = 32'd81; data_exception = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (wb_en || busy) bad = 1;
      @(posedge clock); #1;
      data_resultRDY = 1'b0;
    end
    check("late_ready_no_wb", bad, 0);

`ifdef MULTDIV_TIMEOUT_EN
    // no ready: abort after 40 WAIT cycles, r30 = 4
    run_op(1'b0, 32'd3, 32'd5, 5'd6, 40, 1'b0, 1'b0);
`endif

    // randomized operations
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0: begin ra = $urandom_range(0, 1000); rb = $urandom_range(0, 1000); end
        1: begin ra = $urandom; rb = $urandom; end
        default: begin ra = $urandom; rb = '0; end
      endcase
      run_op(1'($urandom_range(0, 1)), ra, rb, 5'($urandom_range(0, 31)),
             $urandom_range(1, 20), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
